// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: periodic SPI ADC conversion scheduler with round-robin channels and per-channel averaging.
// Optional conversion watchdog enabled by defining ADC_SCHED_TIMEOUT_EN; without it err_timeout is tied low.
module adc_sample_scheduler #(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int NUM_CH        = 2,
  parameter int AVG_LOG2      = 2,
  parameter int DATA_W        = 12,
  parameter int TIMEOUT_CYC   = 1024,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              spi_start,
  output logic [CW-1:0]     spi_ch,
  input  logic [DATA_W-1:0] spi_data,
  input  logic              spi_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [CW-1:0]     res_ch,
  output logic              res_valid,
  output logic              busy,
  output logic              ovr,
  output logic              err_timeout
);
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int SW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  typedef enum logic [2:0] {IDLE, WAIT_TICK, START, WAIT_DATA, PUBLISH} state_t;
  state_t state, nxt;
  logic [15:0]   per_cnt;
  logic [AW-1:0] acc, sum;
  logic [SW-1:0] cnt;
  logic          tick, last, accept, tmo;
  assign tick   = en && per_cnt == 16'(SAMPLE_PERIOD - 1);
  assign sum    = acc + AW'(spi_data);
  assign last   = cnt == SW'((1 << AVG_LOG2) - 1);
  assign accept = state == WAIT_DATA && spi_valid;
`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd;
  assign tmo = state == WAIT_DATA && !spi_valid && wd == WW'(TIMEOUT_CYC - 1);
  // Watchdog: counts cycles spent waiting for the current conversion result
  always_ff @(posedge clk)
    wd <= (!rst_n || state != WAIT_DATA) ? '0 : wd + 1'b1;
  // Sticky flag recording that a conversion was abandoned
  always_ff @(posedge clk)
    if (!rst_n) err_timeout <= 1'b0;
    else if (tmo) err_timeout <= 1'b1;
`else
  assign tmo = 1'b0;
  assign err_timeout = TIMEOUT_CYC < 0;
`endif
  // State register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  // Next-state logic; a discarded (timed-out) sample retries the same channel on the next tick
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = en ? WAIT_TICK : IDLE;
      WAIT_TICK: nxt = !en ? IDLE : tick ? START : WAIT_TICK;
      START:     nxt = WAIT_DATA;
      WAIT_DATA: nxt = accept ? (last ? PUBLISH : WAIT_TICK) : tmo ? WAIT_TICK : WAIT_DATA;
      PUBLISH:   nxt = WAIT_TICK;
      default:   nxt = IDLE;
    endcase
  end
  // State-decoded strobes
  always_comb begin
    spi_start = state == START;
    busy      = state == START || state == WAIT_DATA;
    res_valid = state == PUBLISH;
  end
  // Period counter, accumulator, channel rotation and published result
  always_ff @(posedge clk)
    if (!rst_n) begin
      per_cnt  <= '0;
      acc      <= '0;
      cnt      <= '0;
      spi_ch   <= '0;
      res_data <= '0;
      res_ch   <= '0;
      ovr      <= 1'b0;
    end else begin
      if (en) per_cnt <= tick ? '0 : per_cnt + 1'b1;
      if (tick && state inside {START, WAIT_DATA, PUBLISH}) ovr <= 1'b1;
      if (accept) begin
        acc <= last ? '0 : sum;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          res_data <= DATA_W'(sum >> AVG_LOG2);
          res_ch   <= spi_ch;
        end
      end
      if (state == WAIT_TICK && !en) begin
        acc <= '0;
        cnt <= '0;
      end
      if (state == PUBLISH) spi_ch <= spi_ch == CW'(NUM_CH - 1) ? '0 : spi_ch + 1'b1;
    end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: table-driven bench for adc_sample_scheduler (period 16, 2 channels, 4-sample average).
module tb_adc_sample_scheduler;
  logic        clk = 0, rst_n = 0, en = 0, spi_valid = 0;
  logic [11:0] spi_data = 0;
  logic        spi_start, busy, res_valid, ovr, err_timeout;
  logic [0:0]  spi_ch, res_ch;
  logic [11:0] res_data;
  int cyc = 0, n_vec = 0, n_err = 0, last_start = 0, sc = 0;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam logic [1:0] STICKY = 2'b01;
`else
  localparam logic [1:0] STICKY = 2'b10;
`endif

  typedef struct {
    logic [11:0] d;
    logic        ch;
    logic        pub;
    logic [11:0] res;
  } vec_t;
  vec_t tbl [16];

  adc_sample_scheduler #(
    .SAMPLE_PERIOD(16), .NUM_CH(2), .AVG_LOG2(2), .DATA_W(12), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spi_start(spi_start), .spi_ch(spi_ch),
    .spi_data(spi_data), .spi_valid(spi_valid), .res_data(res_data), .res_ch(res_ch),
    .res_valid(res_valid), .busy(busy), .ovr(ovr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_start(input bit chk_per);
    int k = 0;
    while (spi_start !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("start_seen", 32'(spi_start), 1);
    if (chk_per) chk("start_period", cyc - last_start, 16);
    last_start = cyc;
  endtask

  task automatic run_conv(input logic [11:0] d, input logic ch, input logic pub,
                          input logic [11:0] res, input bit chk_per);
    wait_start(chk_per);
    chk("spi_ch", 32'(spi_ch), 32'(ch));
    @(negedge clk);
    chk("start_pulse_busy", {spi_start, busy}, 2'b01);
    @(negedge clk);
    spi_data  = d;
    spi_valid = 1;
    @(negedge clk);
    spi_valid = 0;
    chk("res_valid", 32'(res_valid), 32'(pub));
    chk("busy_clear", 32'(busy), 0);
    if (pub) begin
      chk("res_data", 32'(res_data), 32'(res));
      chk("res_ch", 32'(res_ch), 32'(ch));
    end
  endtask

  initial begin
    tbl[0]  = '{12'd100,  1'b0, 1'b0, 12'd0};
    tbl[1]  = '{12'd101,  1'b0, 1'b0, 12'd0};
    tbl[2]  = '{12'd102,  1'b0, 1'b0, 12'd0};
    tbl[3]  = '{12'd103,  1'b0, 1'b1, 12'd101};
    tbl[4]  = '{12'd4095, 1'b1, 1'b0, 12'd0};
    tbl[5]  = '{12'd4095, 1'b1, 1'b0, 12'd0};
    tbl[6]  = '{12'd4095, 1'b1, 1'b0, 12'd0};
    tbl[7]  = '{12'd4095, 1'b1, 1'b1, 12'd4095};
    tbl[8]  = '{12'd0,    1'b0, 1'b0, 12'd0};
    tbl[9]  = '{12'd1,    1'b0, 1'b0, 12'd0};
    tbl[10] = '{12'd2,    1'b0, 1'b0, 12'd0};
    tbl[11] = '{12'd3,    1'b0, 1'b1, 12'd1};
    tbl[12] = '{12'd10,   1'b1, 1'b0, 12'd0};
    tbl[13] = '{12'd10,   1'b1, 1'b0, 12'd0};
    tbl[14] = '{12'd10,   1'b1, 1'b0, 12'd0};
    tbl[15] = '{12'd11,   1'b1, 1'b1, 12'd10};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {spi_start, busy, res_valid, ovr, err_timeout, spi_ch, res_ch, res_data}, 0);
    rst_n = 1;
    en    = 1;
    for (int i = 0; i < 16; i++)
      run_conv(tbl[i].d, tbl[i].ch, tbl[i].pub, tbl[i].res, i > 0);
    @(negedge clk);
    chk("res_hold_valid", 32'(res_valid), 0);
    chk("res_hold_data", 32'(res_data), 10);
`ifdef ADC_SCHED_TIMEOUT_EN
    wait_start(1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) chk("wd_pending", {busy, err_timeout}, 2'b10);
    end
    chk("timeout_flags", {busy, err_timeout}, 2'b01);
    run_conv(12'd8, 1'b0, 1'b0, 12'd0, 0);
`else
    wait_start(1);
    chk("ovr_spi_ch", 32'(spi_ch), 0);
    sc = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      sc += 32'(spi_start);
      if (i == 10) chk("hold_busy_ovr_err", {busy, ovr, err_timeout}, 3'b100);
    end
    spi_data  = 12'd8;
    spi_valid = 1;
    @(negedge clk);
    spi_valid = 0;
    chk("ovr_set", {ovr, busy, res_valid}, 3'b100);
    chk("no_extra_start", sc, 0);
`endif
    wait_start(0);
    chk("sticky_flags", {ovr, err_timeout}, 32'(STICKY));
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midconv_reset", {spi_start, busy, res_valid, ovr, err_timeout, spi_ch, res_ch, res_data}, 0);
    rst_n = 1;
    @(negedge clk);
    spi_data  = 12'd999;
    spi_valid = 1;
    @(negedge clk);
    spi_valid = 0;
    chk("stray_valid", {res_valid, busy}, 0);
    repeat (2) @(negedge clk);
    chk("stray_valid_late", 32'(res_valid), 0);
    for (int i = 0; i < 4; i++)
      run_conv(12'd20, 1'b0, i == 3, 12'd20, i > 0);
    run_conv(12'd500, 1'b1, 1'b0, 12'd0, 1);
    en = 0;
    repeat (3) @(negedge clk);
    chk("disabled_idle", {spi_start, busy}, 0);
    en = 1;
    run_conv(12'd40, 1'b1, 1'b0, 12'd0, 0);
    run_conv(12'd40, 1'b1, 1'b0, 12'd0, 1);
    run_conv(12'd40, 1'b1, 1'b0, 12'd0, 1);
    run_conv(12'd44, 1'b1, 1'b1, 12'd41, 1);
    @(negedge clk);
    chk("final_hold", {res_valid, res_data}, 13'd41);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
